sdram_arbiter: RTL and testbench

Round-robin arbiter between the SDRAM cache's downstream request ports and the single-port SDRAM controller. Each port issues one burst transaction (BURST beats) at a time; the arbiter grants one port, forwards its requests and access descriptors to the controller, routes per-beat acknowledges back, and returns the grant after exactly BURST beats. It sits directly downstream of the SDRAM cache (its SRC_* ports connect to the cache's DST_* ports) and directly upstream of the SDRAM controller.

---
 rtl/SDRAM_PKG.sv | 14 +
 rtl/sdram_arbiter.sv | 105 ++++++++++
 tb/tb_sdram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/SDRAM_PKG.sv
// Shared SDRAM types: controller data word and the access descriptor the
// arbiter forwards unchanged from the cache ports to the controller.
package SDRAM_PKG;

  typedef logic [31:0] data_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    logic [3:0]  mask;
  } dram_access_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter granting one SDRAM cache port a full BURST-beat
// transaction on the single-port SDRAM controller at a time.
module sdram_arbiter #(
  parameter int N_SRC = 4,
  parameter int BURST = 8
) (
  input  logic                                CLK,
  input  logic                                RESET_IN,
  input  logic [N_SRC-1:0]                    SRC_WRITE_IN,
  input  SDRAM_PKG::dram_access_t [N_SRC-1:0] SRC_ACS_IN,
  input  logic [N_SRC-1:0]                    SRC_REQ_IN,
  output logic [N_SRC-1:0]                    SRC_ACK_OUT,
  output SDRAM_PKG::data_t [N_SRC-1:0]        SRC_DATA_OUT,
  output logic                                MEM_WRITE_OUT,
  output SDRAM_PKG::dram_access_t             MEM_ACS_OUT,
  output logic                                MEM_REQ_OUT,
  input  logic                                MEM_ACK_IN,
  input  SDRAM_PKG::data_t                    MEM_DATA_IN
);

  localparam int GW = $clog2(N_SRC);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   grant, grant_next;
  logic [GW-1:0]   last, last_next;
  logic [BW-1:0]   beat, beat_next;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic            found;

  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N_SRC - 1);
      beat  <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
      beat  <= beat_next;
    end
  end

  // Scan starts just after the previous owner so every port gets its turn.
  always_comb begin
    pick  = last;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = GW'((int'(last) + k) % N_SRC);
      if (!found && SRC_REQ_IN[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (MEM_ACK_IN) begin
          if (beat == BW'(BURST - 1)) begin
            beat_next  = '0;
            last_next  = grant;
            state_next = IDLE;
          end else begin
            beat_next = beat + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Descriptor and write flag are muxed live so sources may update them after each ack.
  always_comb begin
    MEM_REQ_OUT   = 1'b0;
    MEM_WRITE_OUT = 1'b0;
    MEM_ACS_OUT   = '0;
    SRC_ACK_OUT   = '0;
    if (state == BUSY) begin
      MEM_REQ_OUT        = 1'b1;
      MEM_WRITE_OUT      = SRC_WRITE_IN[grant];
      MEM_ACS_OUT        = SRC_ACS_IN[grant];
      SRC_ACK_OUT[grant] = MEM_ACK_IN;
    end
  end

  assign SRC_DATA_OUT = {N_SRC{MEM_DATA_IN}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios with literal
// expectations plus a randomized phase checked against a transaction-level model.
module tb_sdram_arbiter;
  import SDRAM_PKG::*;

  localparam int N      = 4;
  localparam int B      = 8;
  localparam int AW     = $bits(dram_access_t);
  localparam int ACS_W  = N * AW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N-1:0]           src_write;
  dram_access_t [N-1:0]   src_acs;
  logic [N-1:0]           src_req;
  logic [N-1:0]           src_ack;
  data_t [N-1:0]          src_data;
  logic                   mem_write;
  dram_access_t           mem_acs;
  logic                   mem_req;
  logic                   mem_ack;
  data_t                  mem_data;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Transaction-level model: who owns the controller, how many beats served.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = N - 1;
  int m_done [N] = '{default: 0};

  logic         exp_req;
  logic         exp_write;
  dram_access_t exp_acs;
  logic [N-1:0] exp_ack;

  always #5 clk = ~clk;

  sdram_arbiter #(.N_SRC(N), .BURST(B)) dut (
    .CLK          (clk),
    .RESET_IN     (rst),
    .SRC_WRITE_IN (src_write),
    .SRC_ACS_IN   (src_acs),
    .SRC_REQ_IN   (src_req),
    .SRC_ACK_OUT  (src_ack),
    .SRC_DATA_OUT (src_data),
    .MEM_WRITE_OUT(mem_write),
    .MEM_ACS_OUT  (mem_acs),
    .MEM_REQ_OUT  (mem_req),
    .MEM_ACK_IN   (mem_ack),
    .MEM_DATA_IN  (mem_data)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] wr,
                               input logic ack, input data_t data);
    src_req   = req;
    src_write = wr;
    mem_ack   = ack;
    mem_data  = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Serves one granted burst with back-to-back acks; the caller has just passed the grant edge.
  task automatic serve_burst(input string name, input logic [N-1:0] want_ack, input logic [N-1:0] req,
                             input logic [N-1:0] req_last, input logic [N-1:0] req_after);
    for (int k = 0; k < B; k++) begin
      applyStimulus((k == B - 1) ? req_last : req, src_write, 1'b1, data_t'($urandom));
      #1;
      checkOutput(name, 64'(src_ack), 64'(want_ack));
      next_cycle();
    end
    applyStimulus(req_after, src_write, 1'b0, '0);
    #1;
    checkOutput({name, "_end"}, 64'(mem_req), 64'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && src_req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_beats = 0;
        end
      end
    end else if (mem_ack) begin
      m_beats++;
      if (m_beats == B) begin
        m_done[m_owner]++;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      exp_req   = 1'b0;
      exp_write = 1'b0;
      exp_acs   = '0;
      exp_ack   = '0;
      if (m_owner >= 0) begin
        exp_req   = 1'b1;
        exp_write = src_write[m_owner];
        exp_acs   = src_acs[m_owner];
        if (mem_ack) exp_ack[m_owner] = 1'b1;
      end
      checkOutput("cyc_mem_req", 64'(mem_req), 64'(exp_req));
      checkOutput("cyc_mem_write", 64'(mem_write), 64'(exp_write));
      checkOutput("cyc_mem_acs", 64'(mem_acs), 64'(exp_acs));
      checkOutput("cyc_src_ack", 64'(src_ack), 64'(exp_ack));
      for (int i = 0; i < N; i++) checkOutput("cyc_src_data", 64'(src_data[i]), 64'(mem_data));
    end
  end

  initial begin
    logic [N-1:0] t2_ack [5];
    int           acks;
    int           cyc;
    int           seen [N];
    int           total;
    bit           was_idle;

    t2_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    src_acs = ACS_W'({$urandom, $urandom, $urandom, $urandom});
    applyStimulus('0, '0, 1'b0, '0);

    rst = 1'b1;
    #12;
    checkOutput("reset_mem_req", 64'(mem_req), 64'(0));
    checkOutput("reset_src_ack", 64'(src_ack), 64'(0));
    checkOutput("reset_mem_write", 64'(mem_write), 64'(0));
    checkOutput("reset_mem_acs", 64'(mem_acs), 64'(0));
    check_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // Single read burst from port 2 with known data.
    applyStimulus(4'b0100, 4'b0000, 1'b0, '0);
    #1;
    checkOutput("t1_req_before", 64'(mem_req), 64'(0));
    next_cycle();
    checkOutput("t1_req_rise", 64'(mem_req), 64'(1));
    for (int k = 0; k < B; k++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b1, data_t'(32'h10 + k));
      #1;
      checkOutput("t1_ack", 64'(src_ack), 64'(4'b0100));
      checkOutput("t1_data", 64'(src_data[2]), 64'(32'h10 + k));
      next_cycle();
    end
    applyStimulus('0, '0, 1'b0, '0);
    #1;
    checkOutput("t1_req_fall", 64'(mem_req), 64'(0));

    // All ports requesting: strict rotation from reset with one idle bubble each.
    next_cycle();
    pulse_reset();
    applyStimulus(4'b1111, 4'b0000, 1'b0, '0);
    for (int b = 0; b < 5; b++) begin
      next_cycle();
      checkOutput("t2_busy", 64'(mem_req), 64'(1));
      serve_burst("t2_order", t2_ack[b], 4'b1111, 4'b1111, (b == 4) ? 4'b0000 : 4'b1111);
    end

    // Port 1 write with gapped acks and a descriptor that changes after each ack.
    applyStimulus(4'b0010, 4'b0010, 1'b0, '0);
    next_cycle();
    acks = 0;
    cyc  = 0;
    while (acks < B && cyc < 60) begin
      applyStimulus(4'b0010, 4'b0010, (cyc % 3) == 2, data_t'($urandom));
      #1;
      checkOutput("t3_acs", 64'(mem_acs), 64'(src_acs[1]));
      checkOutput("t3_write", 64'(mem_write), 64'(1));
      checkOutput("t3_req", 64'(mem_req), 64'(1));
      next_cycle();
      if (mem_ack) begin
        acks++;
        src_acs[1] = AW'($urandom);
      end
      cyc++;
    end
    checkOutput("t3_acks", 64'(acks), 64'(B));
    checkOutput("t3_cycles", 64'(cyc), 64'(24));
    applyStimulus('0, '0, 1'b0, '0);
    #1;
    checkOutput("t3_end", 64'(mem_req), 64'(0));

    // Port 3 finishes while port 0 raises its request; port 0 must win next.
    next_cycle();
    applyStimulus(4'b1000, 4'b0000, 1'b0, '0);
    next_cycle();
    serve_burst("t4_p3", 4'b1000, 4'b1000, 4'b1001, 4'b1001);
    next_cycle();
    serve_burst("t4_p0_first", 4'b0001, 4'b1001, 4'b1001, 4'b1000);
    next_cycle();
    serve_burst("t4_p3_again", 4'b1000, 4'b1000, 4'b0000, 4'b0000);

    // Spurious acks while idle must be ignored entirely.
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus('0, '0, 1'b1, data_t'($urandom));
      #1;
      checkOutput("t5_spurious_ack", 64'(src_ack), 64'(0));
      checkOutput("t5_spurious_req", 64'(mem_req), 64'(0));
      next_cycle();
    end
    applyStimulus(4'b0010, 4'b0000, 1'b0, '0);
    next_cycle();
    serve_burst("t5_full", 4'b0010, 4'b0010, 4'b0000, 4'b0000);

    // Reset in the middle of port 0's burst abandons it.
    applyStimulus(4'b0001, 4'b0000, 1'b0, '0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b1, data_t'($urandom));
      #1;
      checkOutput("t6_pre_ack", 64'(src_ack), 64'(4'b0001));
      next_cycle();
    end
    applyStimulus(4'b0001, 4'b0000, 1'b1, data_t'($urandom));
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_req", 64'(mem_req), 64'(0));
    checkOutput("t6_async_ack", 64'(src_ack), 64'(0));
    checkOutput("t6_async_acs", 64'(mem_acs), 64'(0));
    rst = 1'b0;
    mem_ack = 1'b0;
    next_cycle();
    serve_burst("t6_full", 4'b0001, 4'b0001, 4'b0000, 4'b0000);

    // Random traffic checked only by the per-cycle model comparison.
    next_cycle();
    for (int p = 0; p < N; p++) seen[p] = m_done[p];
    total = 0;
    for (int p = 0; p < N; p++) total -= m_done[p];
    was_idle = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++) begin
        if (src_req[p]) begin
          if (m_done[p] != seen[p]) begin
            seen[p] = m_done[p];
            if ($urandom_range(1) == 1) src_req[p] = 1'b0;
            else src_write[p] = 1'($urandom_range(1));
          end
        end else if ($urandom_range(3) == 0) begin
          src_req[p]   = 1'b1;
          src_write[p] = 1'($urandom_range(1));
        end
      end
      if (m_owner >= 0) mem_ack = ($urandom_range(2) != 0);
      else mem_ack = was_idle && ($urandom_range(7) == 0);
      was_idle = (m_owner < 0);
      mem_data = data_t'($urandom);
      src_acs  = ACS_W'({$urandom, $urandom, $urandom, $urandom});
      next_cycle();
    end
    for (int p = 0; p < N; p++) total += m_done[p];
    checkOutput("rand_progress", 64'(total > 20), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
